wb_timer_arbiter: RTL and testbench
===================================

Name: wb_timer_arbiter

Overview:
- Wishbone arbiter that lets NUM_MASTERS masters (e.g. CPU core and NoC bridge) share the single Wishbone slave port of the timer peripheral.
- Round-robin grant, locked for the whole bus cycle (cyc held).
- Sits between the masters' Wishbone buses and the timer wrapper slave port.
- Registered grant FSM.
- Optional watchdog that aborts a hung slave access.

Parameters:
- NUM_MASTERS, 2, number of requesting masters, legal 2..4.
- TIMEOUT_CYCLES, 255, stb-without-ack cycles before abort; only used with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m_adr_i  in  NUM_MASTERS*32  master addresses; master k occupies bits [32k+31:32k].
- m_dat_i  in  NUM_MASTERS*32  master write data, same packing.
- m_sel_i  in  NUM_MASTERS*4  master byte selects.
- m_we_i  in  NUM_MASTERS  master write enables.
- m_cyc_i  in  NUM_MASTERS  master cycle requests.
- m_stb_i  in  NUM_MASTERS  master strobes.
- m_dat_o  out  32  slave read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_err_o  out  NUM_MASTERS  per-master error; timeout abort only.
- s_adr_o  out  32  to timer slave.
- s_dat_o  out  32  to timer slave.
- s_sel_o  out  4  to timer slave.
- s_we_o  out  1  to timer slave.
- s_cyc_o  out  1  to timer slave.
- s_stb_o  out  1  to timer slave.
- s_dat_i  in  32  timer read data.
- s_ack_i  in  1  timer acknowledge.
- gnt_o  out  NUM_MASTERS  one-hot current grant, debug/status.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, gnt=0, rr_ptr=0, timeout counter=0.
  - All s_*_o = 0; m_ack_o, m_err_o, gnt_o = 0.
  - Asserting reset mid-transaction drops s_cyc_o/s_stb_o immediately. No ack is delivered.
- FSM states IDLE, BUSY; ABORT is added only with WB_ARB_TIMEOUT_EN.
- IDLE:
  - If any m_cyc_i is high at a clock edge, pick the first requester searching upward from rr_ptr, wrapping modulo NUM_MASTERS.
  - Register the one-hot grant and go to BUSY.
  - Latency: cyc high at edge N → s_cyc_o high during cycle N+1.
  - Requests asserted and dropped between edges are ignored.
- BUSY:
  - s_adr/dat/sel/we_o are a combinational mux of the granted master's inputs.
  - s_cyc_o = granted m_cyc_i; s_stb_o = granted m_stb_i.
  - m_ack_o[g] = s_ack_i for the granted master g; all other ack bits are 0.
  - m_dat_o = s_dat_i at all times.
  - Grant holds while the granted m_cyc_i stays high; multiple stb/ack beats within one cyc are allowed.
  - Granted cyc low at an edge → IDLE, rr_ptr = (g+1) mod NUM_MASTERS, gnt cleared.
- Back-to-back: one mandatory IDLE bubble between grants, so masters alternate when both hold cyc.
- Ack and cyc drop in the same cycle: ack is still routed that cycle; release happens at the next edge.
- Non-granted masters:
  - Never see ack.
  - May hold cyc/stb indefinitely; they wait with no side effects.
- Outside BUSY, every s_*_o is 0 regardless of master inputs.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=0; it clears on ack or when leaving BUSY.
  - When the count reaches TIMEOUT_CYCLES, go to ABORT for exactly one cycle:
    - s_cyc_o = s_stb_o = 0;
    - m_err_o[g] = 1 for that cycle;
    - rr_ptr = g+1.
  - ABORT then goes to IDLE.
  - A timed-out master must drop cyc; if it still holds cyc, it re-arbitrates normally.
- Without the macro: m_err_o is tied to 0, no counter exists, and BUSY waits indefinitely for ack.

Decomposition:
- Package wb_arb_pkg:
  - state enum {IDLE, BUSY, ABORT};
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4;
  - function for wrap-around pointer increment.
- One sub-module, rr_picker: combinational round-robin selector taking the req vector and rr_ptr, returning a one-hot grant and its index.
- FSM, muxes and timeout counter live in wb_timer_arbiter.

Test Plan:
- Reset mid-cycle: master0 granted with s_stb_o=1, assert rst_i → s_cyc_o/s_stb_o/gnt_o drop to 0 asynchronously; after release, rr_ptr=0.
- Single master write: master1 writes 0x0000_0010 to adr 0x8 → s_cyc_o high one cycle after m_cyc_i[1]; s_adr_o=0x8, s_dat_o=0x10; m_ack_o=2'b10 exactly when s_ack_i=1.
- Contention: both masters raise cyc in the same cycle from reset → master0 granted first, then master1 after one IDLE bubble. Repeated simultaneous requests alternate 0,1,0,1.
- Locked burst: master0 holds cyc for 3 stb/ack reads of 0x0,0x4,0x8 while master1 requests → master1 gnt stays 0 until master0 drops cyc; master1 never sees ack meanwhile.
- Read data: granted master reads with s_dat_i=0xDEAD_BEEF → m_dat_o=0xDEAD_BEEF, ack only on the granted bit.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks → m_err_o[g] pulses for 1 cycle after 8 stb cycles, s_cyc_o drops, and the other pending master is granted next.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone timer arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/wb_timer_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester at or above ptr, wrapping.
module rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  logic [IDX_W-1:0] cand [NUM_MASTERS];

  // cand[k] is the master index k positions above ptr, modulo NUM_MASTERS.
  genvar gi;
  for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum      = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign cand[gi] = (sum >= (IDX_W+1)'(NUM_MASTERS))
                      ? IDX_W'(sum - (IDX_W+1)'(NUM_MASTERS))
                      : IDX_W'(sum);
  end

  // Scan from the farthest candidate down so the nearest requester wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        idx   = cand[i];
        valid = 1'b1;
      end
    end
    gnt = valid ? (NUM_MASTERS'(1) << idx) : '0;
  end

endmodule

// File: rtl/wb_timer_arbiter.sv
// Round-robin Wishbone arbiter in front of the timer slave, grant locked per cyc.
// Define WB_ARB_TIMEOUT_EN to add the hung-slave watchdog and ABORT state.
module wb_timer_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  output logic [WB_DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [WB_ADR_W-1:0]             s_adr_o,
  output logic [WB_DAT_W-1:0]             s_dat_o,
  output logic [WB_SEL_W-1:0]             s_sel_o,
  output logic                            s_we_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  input  logic [WB_DAT_W-1:0]             s_dat_i,
  input  logic                            s_ack_i,
  output logic [NUM_MASTERS-1:0]          gnt_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_timer_arbiter: NUM_MASTERS must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e             state_reg, state_next;
  logic [NUM_MASTERS-1:0] gnt_reg, gnt_next;
  logic [IDX_W-1:0]       gidx_reg, gidx_next;
  logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   busy, g_cyc, g_stb, timeout_hit;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req   (m_cyc_i),
    .ptr   (rr_ptr_reg),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign busy  = (state_reg == BUSY);
  assign g_cyc = m_cyc_i[gidx_reg];
  assign g_stb = m_stb_i[gidx_reg];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Counts strobe cycles without ack; the TIMEOUT_CYCLES-th such cycle aborts.
  always_comb begin
    cnt_next    = '0;
    timeout_hit = 1'b0;
    if (busy && g_cyc && !s_ack_i) begin
      cnt_next = cnt_reg;
      if (g_stb) begin
        if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_reg <= '0;
    else       cnt_reg <= cnt_next;
  end

  assign m_err_o = (state_reg == ABORT) ? gnt_reg : '0;
`else
  assign timeout_hit = 1'b0;
  assign m_err_o     = '0;
`endif

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    gidx_next   = gidx_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = BUSY;
          gnt_next   = pick_gnt;
          gidx_next  = pick_idx;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_next  = IDLE;
          gnt_next    = '0;
          rr_ptr_next = IDX_W'(rr_wrap_inc(32'(gidx_reg), unsigned'(NUM_MASTERS)));
        end else if (timeout_hit) begin
          // Grant is kept through ABORT so the error reaches the right master.
          state_next  = ABORT;
          rr_ptr_next = IDX_W'(rr_wrap_inc(32'(gidx_reg), unsigned'(NUM_MASTERS)));
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      gidx_reg   <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      gidx_reg   <= gidx_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign s_adr_o = busy ? m_adr_i[gidx_reg*WB_ADR_W +: WB_ADR_W] : '0;
  assign s_dat_o = busy ? m_dat_i[gidx_reg*WB_DAT_W +: WB_DAT_W] : '0;
  assign s_sel_o = busy ? m_sel_i[gidx_reg*WB_SEL_W +: WB_SEL_W] : '0;
  assign s_we_o  = busy & m_we_i[gidx_reg];
  assign s_cyc_o = busy & g_cyc;
  assign s_stb_o = busy & g_stb;

  assign m_ack_o = (busy && s_ack_i) ? gnt_reg : '0;
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_reg;

endmodule

// File: tb/tb_wb_timer_arbiter.sv
// Self-checking bench for wb_timer_arbiter: vector table, directed corner cases, random vs. model.
module tb_wb_timer_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N*32-1:0] m_adr_i, m_dat_i;
  logic [N*4-1:0]  m_sel_i;
  logic [N-1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
  logic [31:0]     s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]      s_sel_o;
  logic            s_we_o, s_cyc_o, s_stb_o, s_ack_i;

  always #5 clk = ~clk;

  wb_timer_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] adr [N];
  logic [31:0] dat [N];
  logic [3:0]  sel [N];
  logic [N-1:0] we;

  typedef struct {
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        ack;
    logic [31:0] sdat;
    logic [1:0]  e_gnt;
    logic        e_scyc;
    logic [1:0]  e_ack;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs just after a rising edge, leave time to settle before checks.
  task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic ack,
                       input logic [31:0] sdat);
    @(posedge clk);
    #1;
    m_cyc_i = cyc;
    m_stb_i = stb;
    s_ack_i = ack;
    s_dat_i = sdat;
    m_adr_i = {adr[1], adr[0]};
    m_dat_i = {dat[1], dat[0]};
    m_sel_i = {sel[1], sel[0]};
    m_we_i  = we;
    #3;
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0; s_dat_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Reference model state
  bit busy_m, abort_m;
  int g_m, rr_m, stall_m;

  task automatic model_reset();
    busy_m = 0; abort_m = 0; g_m = 0; rr_m = 0; stall_m = 0;
  endtask

  task automatic model_check(input logic [1:0] cyc, input logic [1:0] stb, input logic ack,
                             input logic [31:0] sdat);
    logic [1:0] eg, eack, eerr;
    eg   = (busy_m || abort_m) ? 2'(1 << g_m) : 2'b00;
    eack = (busy_m && ack) ? 2'(1 << g_m) : 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
    eerr = abort_m ? 2'(1 << g_m) : 2'b00;
`else
    eerr = 2'b00;
`endif
    chk("rnd_gnt",  gnt_o,   eg);
    chk("rnd_ack",  m_ack_o, eack);
    chk("rnd_err",  m_err_o, eerr);
    chk("rnd_scyc", s_cyc_o, busy_m ? cyc[g_m] : 1'b0);
    chk("rnd_sstb", s_stb_o, busy_m ? stb[g_m] : 1'b0);
    chk("rnd_sadr", s_adr_o, busy_m ? adr[g_m] : 32'h0);
    chk("rnd_sdat", s_dat_o, busy_m ? dat[g_m] : 32'h0);
    chk("rnd_ssel", s_sel_o, busy_m ? sel[g_m] : 4'h0);
    chk("rnd_swe",  s_we_o,  busy_m ? we[g_m] : 1'b0);
    chk("rnd_mdat", m_dat_o, sdat);
  endtask

  // Advance the model across the clock edge that samples these inputs.
  task automatic model_step(input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
    if (abort_m) begin
      abort_m = 0;
    end else if (!busy_m) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr_m + k) % N;
        if (!busy_m && cyc[c]) begin
          busy_m = 1; g_m = c; stall_m = 0;
        end
      end
    end else if (!cyc[g_m]) begin
      busy_m = 0; rr_m = (g_m + 1) % N; stall_m = 0;
    end else if (ack) begin
      stall_m = 0;
    end else if (stb[g_m]) begin
      stall_m++;
`ifdef WB_ARB_TIMEOUT_EN
      if (stall_m == TO) begin
        busy_m = 0; abort_m = 1; rr_m = (g_m + 1) % N; stall_m = 0;
      end
`endif
    end
  endtask

  initial begin
    rst_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      adr[k] = 32'h100 * (k + 1); dat[k] = 32'hA000 + k; sel[k] = 4'hF;
    end
    we = 2'b00;

    // Reset holds all outputs low even with active master inputs.
    m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    m_adr_i = {adr[1], adr[0]}; m_dat_i = {dat[1], dat[0]}; m_sel_i = 8'hFF; m_we_i = 2'b11;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_scyc", s_cyc_o, 1'b0);
    chk("rst_sstb", s_stb_o, 1'b0);
    chk("rst_sadr", s_adr_o, 32'h0);
    chk("rst_gnt",  gnt_o,   2'b00);
    chk("rst_ack",  m_ack_o, 2'b00);
    chk("rst_err",  m_err_o, 2'b00);
    clear_inputs();
    @(negedge clk);
    rst_i = 1'b0;

    // Contention, alternation, ack routed in the cycle cyc drops.
    vecs[0] = '{2'b11, 2'b11, 1'b0, 32'h0000_0001, 2'b00, 1'b0, 2'b00};
    vecs[1] = '{2'b11, 2'b11, 1'b1, 32'h0000_0002, 2'b01, 1'b1, 2'b01};
    vecs[2] = '{2'b10, 2'b10, 1'b0, 32'h0000_0003, 2'b01, 1'b0, 2'b00};
    vecs[3] = '{2'b11, 2'b11, 1'b0, 32'h0000_0004, 2'b00, 1'b0, 2'b00};
    vecs[4] = '{2'b11, 2'b11, 1'b1, 32'h0000_0005, 2'b10, 1'b1, 2'b10};
    vecs[5] = '{2'b01, 2'b01, 1'b0, 32'h0000_0006, 2'b10, 1'b0, 2'b00};
    vecs[6] = '{2'b11, 2'b11, 1'b0, 32'h0000_0007, 2'b00, 1'b0, 2'b00};
    vecs[7] = '{2'b11, 2'b11, 1'b1, 32'h0000_0008, 2'b01, 1'b1, 2'b01};
    vecs[8] = '{2'b10, 2'b10, 1'b1, 32'h0000_0009, 2'b01, 1'b0, 2'b01};
    vecs[9] = '{2'b00, 2'b00, 1'b0, 32'h0000_000A, 2'b00, 1'b0, 2'b00};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].cyc, vecs[i].stb, vecs[i].ack, vecs[i].sdat);
      chk($sformatf("vec%0d_gnt", i),  gnt_o,   vecs[i].e_gnt);
      chk($sformatf("vec%0d_scyc", i), s_cyc_o, vecs[i].e_scyc);
      chk($sformatf("vec%0d_ack", i),  m_ack_o, vecs[i].e_ack);
      chk($sformatf("vec%0d_mdat", i), m_dat_o, vecs[i].sdat);
      chk($sformatf("vec%0d_err", i),  m_err_o, 2'b00);
    end

    // Reset mid-transaction with rr_ptr moved off zero.
    do_reset();
    drive(2'b01, 2'b01, 1'b0, 32'h0);
    drive(2'b01, 2'b01, 1'b0, 32'h0);
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    drive(2'b10, 2'b10, 1'b0, 32'h0);
    drive(2'b10, 2'b10, 1'b0, 32'h0);
    chk("mid_gnt_before", gnt_o, 2'b10);
    chk("mid_stb_before", s_stb_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_scyc", s_cyc_o, 1'b0);
    chk("mid_rst_sstb", s_stb_o, 1'b0);
    chk("mid_rst_gnt",  gnt_o,   2'b00);
    chk("mid_rst_ack",  m_ack_o, 2'b00);
    clear_inputs();
    @(negedge clk);
    rst_i = 1'b0;
    drive(2'b11, 2'b11, 1'b0, 32'h0);
    chk("post_rst_idle", gnt_o, 2'b00);
    drive(2'b11, 2'b11, 1'b0, 32'h0);
    chk("post_rst_rr0", gnt_o, 2'b01);
    drive(2'b00, 2'b00, 1'b0, 32'h0);

    // Single master write from master 1.
    do_reset();
    adr[1] = 32'h8; dat[1] = 32'h10; sel[1] = 4'hF; we = 2'b10;
    drive(2'b10, 2'b10, 1'b0, 32'h0);
    chk("wr_latency", s_cyc_o, 1'b0);
    drive(2'b10, 2'b10, 1'b0, 32'h0);
    chk("wr_scyc", s_cyc_o, 1'b1);
    chk("wr_sadr", s_adr_o, 32'h8);
    chk("wr_sdat", s_dat_o, 32'h10);
    chk("wr_ssel", s_sel_o, 4'hF);
    chk("wr_swe",  s_we_o,  1'b1);
    chk("wr_noack", m_ack_o, 2'b00);
    drive(2'b10, 2'b10, 1'b1, 32'h0);
    chk("wr_ack", m_ack_o, 2'b10);
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    chk("wr_drop", s_cyc_o, 1'b0);

    // Locked 3-beat read burst from master 0 while master 1 waits.
    we = 2'b00;
    drive(2'b11, 2'b11, 1'b0, 32'h0);
    chk("burst_idle", gnt_o, 2'b00);
    for (int b = 0; b < 3; b++) begin
      logic [31:0] rd;
      rd = (b == 2) ? 32'hDEAD_BEEF : 32'h5500 + b;
      adr[0] = 32'(4 * b);
      drive(2'b11, 2'b11, 1'b0, rd);
      chk($sformatf("burst%0d_gnt", b),  gnt_o,   2'b01);
      chk($sformatf("burst%0d_sadr", b), s_adr_o, 32'(4 * b));
      chk($sformatf("burst%0d_wait", b), m_ack_o, 2'b00);
      drive(2'b11, 2'b11, 1'b1, rd);
      chk($sformatf("burst%0d_ack", b),  m_ack_o, 2'b01);
      chk($sformatf("burst%0d_mdat", b), m_dat_o, rd);
    end
    drive(2'b10, 2'b10, 1'b0, 32'h0);
    chk("burst_release_gnt", gnt_o, 2'b01);
    chk("burst_release_scyc", s_cyc_o, 1'b0);
    drive(2'b10, 2'b10, 1'b0, 32'h0);
    chk("burst_bubble", gnt_o, 2'b00);
    drive(2'b10, 2'b10, 1'b0, 32'h0);
    chk("burst_next_gnt", gnt_o, 2'b10);

`ifdef WB_ARB_TIMEOUT_EN
    // Hung slave: master 0 granted, never acked; master 1 pending.
    do_reset();
    drive(2'b11, 2'b11, 1'b0, 32'h0);
    for (int c = 0; c < TO; c++) begin
      drive(2'b11, 2'b11, 1'b0, 32'h0);
      chk($sformatf("to_wait%0d_stb", c), s_stb_o, 1'b1);
      chk($sformatf("to_wait%0d_err", c), m_err_o, 2'b00);
    end
    drive(2'b11, 2'b11, 1'b0, 32'h0);
    chk("to_abort_err",  m_err_o, 2'b01);
    chk("to_abort_scyc", s_cyc_o, 1'b0);
    chk("to_abort_sstb", s_stb_o, 1'b0);
    drive(2'b11, 2'b11, 1'b0, 32'h0);
    chk("to_after_err", m_err_o, 2'b00);
    chk("to_after_gnt", gnt_o,   2'b00);
    drive(2'b11, 2'b11, 1'b0, 32'h0);
    chk("to_next_gnt", gnt_o, 2'b10);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    begin
      logic [1:0] cyc_r, stb_r;
      logic       ack_r;
      logic [31:0] sd_r;
      int ack_pct;
      cyc_r = '0;
      for (int t = 0; t < 3000; t++) begin
        ack_pct = ((t / 250) % 2 == 0) ? 40 : 3;
        for (int k = 0; k < N; k++) begin
          if (cyc_r[k]) cyc_r[k] = ($urandom_range(0, 7) != 0);
          else          cyc_r[k] = ($urandom_range(0, 3) == 0);
          stb_r[k] = cyc_r[k] && ($urandom_range(0, 3) != 0);
          adr[k] = $urandom; dat[k] = $urandom; sel[k] = 4'($urandom);
          we[k]  = 1'($urandom);
        end
        ack_r = ($urandom_range(0, 99) < ack_pct);
        sd_r  = $urandom;
        drive(cyc_r, stb_r, ack_r, sd_r);
        model_check(cyc_r, stb_r, ack_r, sd_r);
        model_step(cyc_r, stb_r, ack_r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
